// File: rtl/inst_fetch_multi.sv
// rtl/inst_fetch_multi.sv - multi-outstanding fetch stage: I-cache requests, pending-info FIFO, fetch queue
// Optional macro IF_PERF_CNT_EN adds request/stall/drop performance counters.
module inst_fetch_multi #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'h1c000000
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic [ADDR_WIDTH-1:0]             i_flush_pc,
  input  logic                              i_branch,
  input  logic [ADDR_WIDTH-1:0]             i_predict_pc,
  output logic                              o_req_valid,
  input  logic                              i_req_ready,
  output logic [ADDR_WIDTH-1:0]             o_req_addr,
  input  logic                              i_resp_valid,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] i_resp_data,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [ADDR_WIDTH-1:0]             o_out_pc,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] o_out_inst,
  output logic [FETCH_WIDTH-1:0]            o_out_mask,
  output logic                              o_out_branch,
  output logic                              o_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                       o_perf_req_cnt,
  output logic [31:0]                       o_perf_stall_cnt,
  output logic [31:0]                       o_perf_drop_cnt
`endif
);

  localparam int GB   = FETCH_WIDTH * 4;
  localparam int OFFS = $clog2(GB);
  localparam int SW   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = PW + 1;
  localparam int CW1  = CW + 1;
  localparam int DW   = FETCH_WIDTH * INST_WIDTH;

  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_tag;
  logic [CW-1:0]          r_outstanding;
  logic [CW-1:0]          r_drop;

  logic [ADDR_WIDTH-1:0]  r_pi_pc   [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] r_pi_mask [QUEUE_DEPTH];
  logic                   r_pi_tag  [QUEUE_DEPTH];
  logic [CW-1:0]          r_pi_wptr, r_pi_rptr;

  logic [ADDR_WIDTH-1:0]  r_q_pc   [QUEUE_DEPTH];
  logic [DW-1:0]          r_q_data [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] r_q_mask [QUEUE_DEPTH];
  logic                   r_q_tag  [QUEUE_DEPTH];
  logic [CW-1:0]          r_q_wptr, r_q_rptr;

  logic [ADDR_WIDTH-1:0]  w_req_addr;
  logic [SW-1:0]          w_slot;
  logic [FETCH_WIDTH-1:0] w_req_mask;
  logic [CW-1:0]          w_occ;
  logic                   w_credit, w_req_valid, w_hs, w_q_empty, w_out_valid;
  logic                   w_pop, w_push, w_drop_resp;

  assign w_req_addr = {r_pc[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
  assign w_slot     = SW'((r_pc >> 2) & ADDR_WIDTH'(FETCH_WIDTH - 1));

  always_comb begin
    w_req_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_req_mask[i] = (SW'(i) >= w_slot);
    end
  end

  // Credit counts in-flight requests against queue space so every response has a slot.
  assign w_occ       = r_q_wptr - r_q_rptr;
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, w_occ}) < CW1'(QUEUE_DEPTH);
  assign w_req_valid = !i_rst && !i_flush && w_credit;
  assign w_hs        = w_req_valid && i_req_ready;
  assign w_q_empty   = (r_q_wptr == r_q_rptr);
  assign w_out_valid = !i_rst && !w_q_empty;
  assign w_pop       = w_out_valid && i_out_ready && !i_flush;
  assign w_drop_resp = i_resp_valid && (r_drop != '0);
  assign w_push      = !i_rst && !i_flush && i_resp_valid && (r_drop == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_VECTOR;
      r_tag         <= 1'b0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_pi_wptr     <= '0;
      r_pi_rptr     <= '0;
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_hs) - CW'(i_resp_valid);
      if (i_flush) begin
        r_pc      <= i_flush_pc;
        r_tag     <= 1'b0;
        r_drop    <= r_outstanding - CW'(i_resp_valid);
        r_pi_wptr <= '0;
        r_pi_rptr <= '0;
        r_q_wptr  <= '0;
        r_q_rptr  <= '0;
      end else begin
        if (i_branch) begin
          r_pc  <= i_predict_pc;
          r_tag <= 1'b1;
        end else if (w_hs) begin
          r_pc  <= w_req_addr + ADDR_WIDTH'(GB);
          r_tag <= 1'b0;
        end
        if (w_drop_resp) r_drop <= r_drop - CW'(1);
        if (w_hs) r_pi_wptr <= r_pi_wptr + CW'(1);
        if (w_push) begin
          r_pi_rptr <= r_pi_rptr + CW'(1);
          r_q_wptr  <= r_q_wptr + CW'(1);
        end
        if (w_pop) r_q_rptr <= r_q_rptr + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_hs) begin
      r_pi_pc[r_pi_wptr[PW-1:0]]   <= r_pc;
      r_pi_mask[r_pi_wptr[PW-1:0]] <= w_req_mask;
      r_pi_tag[r_pi_wptr[PW-1:0]]  <= r_tag;
    end
    if (w_push) begin
      r_q_pc[r_q_wptr[PW-1:0]]   <= r_pi_pc[r_pi_rptr[PW-1:0]];
      r_q_data[r_q_wptr[PW-1:0]] <= i_resp_data;
      r_q_mask[r_q_wptr[PW-1:0]] <= r_pi_mask[r_pi_rptr[PW-1:0]];
      r_q_tag[r_q_wptr[PW-1:0]]  <= r_pi_tag[r_pi_rptr[PW-1:0]];
    end
  end

  assign o_req_valid  = w_req_valid;
  assign o_req_addr   = w_req_addr;
  assign o_out_valid  = w_out_valid;
  assign o_out_pc     = r_q_pc[r_q_rptr[PW-1:0]];
  assign o_out_inst   = r_q_data[r_q_rptr[PW-1:0]];
  assign o_out_mask   = r_q_mask[r_q_rptr[PW-1:0]];
  assign o_out_branch = r_q_tag[r_q_rptr[PW-1:0]];
  assign o_busy       = !i_rst && ((r_outstanding != '0) || !w_q_empty);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_req, r_perf_stall, r_perf_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_req   <= '0;
      r_perf_stall <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_hs) r_perf_req <= r_perf_req + 32'd1;
      if (!w_credit) r_perf_stall <= r_perf_stall + 32'd1;
      if (i_resp_valid && (i_flush || (r_drop != '0))) r_perf_drop <= r_perf_drop + 32'd1;
    end
  end

  assign o_perf_req_cnt   = r_perf_req;
  assign o_perf_stall_cnt = r_perf_stall;
  assign o_perf_drop_cnt  = r_perf_drop;
`endif

endmodule
